// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the AC motor ramp sequencer: state encoding,
// MOD_DELAY_UMIN field positions and the post-reset configuration word.
package ac_motor_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ALIGN     = 3'd1,
    RAMP_UP   = 3'd2,
    RUN       = 3'd3,
    RAMP_DOWN = 3'd4,
    FAULT     = 3'd5
  } state_e;

  localparam int MOD_BIT   = 15;
  localparam int DELAY_MSB = 14;
  localparam int DELAY_LSB = 8;
  localparam int UMIN_MSB  = 7;
  localparam int UMIN_LSB  = 1;

  localparam logic [15:0] CFG_RESET = 16'h8000;

  // The ramp tick only advances in the power-moving states.
  function automatic logic is_ramping(input state_e s);
    return (s == RAMP_UP) || (s == RUN) || (s == RAMP_DOWN);
  endfunction

endpackage

// File: rtl/ac_motor_ramp_tick.sv
// Clearable STEP_DIV divider: one registered tick per STEP_DIV enabled clocks,
// restarting from zero whenever clr is asserted or en drops.
module ac_motor_ramp_tick #(
  parameter int STEP_DIV = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(STEP_DIV - 2);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Counter and tick flag; tick is raised for the cycle in which the count sits at its last value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r  <= CNT_ZERO;
      tick_r <= 1'b0;
    end else if (clr || !en) begin
      cnt_r  <= CNT_ZERO;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= (cnt_r == CNT_LAST) ? CNT_ZERO : cnt_r + CW'(1);
      tick_r <= (cnt_r == CNT_PRE);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/ac_motor_ramp_sequencer.sv
// Per-motor sequencer: alignment, rate-limited ramps and latched fault shutdown,
// driving the POWER command and packed MOD_DELAY_UMIN word of the motor control block.
module ac_motor_ramp_sequencer
  import ac_motor_pkg::*;
#(
  parameter int resolution_bits = 12,
  parameter int STEP_DIV        = 1000,
  parameter int RAMP_STEP       = 1,
  parameter int ALIGN_CYCLES    = 4096
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ENABLE,
  input  logic [resolution_bits-1:0] TARGET,
  input  logic                       FAULT_IN,
  input  logic                       CLR_FAULT,
  input  logic                       CFG_MODULATION,
  input  logic [6:0]                 CFG_DELAY,
  input  logic [6:0]                 CFG_UMIN,
  output logic [resolution_bits-1:0] POWER,
  output logic [15:0]                MOD_DELAY_UMIN,
  output logic                       RUNNING,
  output logic                       BUSY,
  output logic                       FAULT_LATCHED
);

  localparam int RW  = resolution_bits;
  localparam int RW1 = resolution_bits + 1;
  localparam int AW  = (ALIGN_CYCLES > 1) ? $clog2(ALIGN_CYCLES) : 1;

  localparam logic [AW-1:0]  ALIGN_LAST = AW'(ALIGN_CYCLES - 1);
  localparam logic [AW-1:0]  ALIGN_ZERO = {AW{1'b0}};
  localparam logic [RW:0]    STEP_W     = RW1'(RAMP_STEP);
  localparam logic [RW-1:0]  P_MAX      = {RW{1'b1}};
  localparam logic [RW-1:0]  P_ZERO     = {RW{1'b0}};

  // Add is one bit wider so a carry saturates instead of wrapping.
  function automatic logic [RW-1:0] sat_add(input logic [RW-1:0] a);
    logic [RW:0] s;
    s = {1'b0, a} + STEP_W;
    return s[RW] ? P_MAX : s[RW-1:0];
  endfunction

  function automatic logic [RW-1:0] sat_sub(input logic [RW-1:0] a);
    return ({1'b0, a} > STEP_W) ? (a - STEP_W[RW-1:0]) : P_ZERO;
  endfunction

  state_e         state_r, state_next_s;
  logic [RW-1:0]  power_r, power_next_s;
  logic [AW-1:0]  align_r, align_next_s;
  logic [15:0]    mod_r;
  logic           running_r, busy_r, fault_r;
  logic [15:0]    cfg_s;
  logic [RW-1:0]  up_s, dn_s, toward_s, align_lvl_s;
  logic           tick_s, tick_clr_s, tick_en_s;

  assign up_s        = sat_add(power_r);
  assign dn_s        = sat_sub(power_r);
  assign align_lvl_s = RW'({mod_r[UMIN_MSB:UMIN_LSB], 1'b0});
  assign tick_en_s   = is_ramping(state_r);
  assign tick_clr_s  = (state_next_s != state_r);

  ac_motor_ramp_tick #(.STEP_DIV(STEP_DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .en   (tick_en_s),
    .clr  (tick_clr_s),
    .tick (tick_s)
  );

  // Assemble the configuration word from the live CFG inputs.
  always_comb begin
    cfg_s                      = 16'h0000;
    cfg_s[MOD_BIT]             = CFG_MODULATION;
    cfg_s[DELAY_MSB:DELAY_LSB] = CFG_DELAY;
    cfg_s[UMIN_MSB:UMIN_LSB]   = CFG_UMIN;
  end

  // One rate-limited step toward TARGET, clamped so it never overshoots.
  always_comb begin
    toward_s = power_r;
    if (power_r < TARGET) begin
      toward_s = (up_s > TARGET) ? TARGET : up_s;
    end else if (power_r > TARGET) begin
      toward_s = (dn_s < TARGET) ? TARGET : dn_s;
    end else begin
      toward_s = power_r;
    end
  end

  // Next-state and next-POWER; FAULT_IN overrides everything, ENABLE low beats a coincident tick.
  always_comb begin
    state_next_s = state_r;
    power_next_s = power_r;
    align_next_s = align_r;
    if (FAULT_IN) begin
      state_next_s = FAULT;
      power_next_s = P_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          power_next_s = P_ZERO;
          if (ENABLE) begin
            state_next_s = ALIGN;
            power_next_s = RW'({CFG_UMIN, 1'b0});
            align_next_s = ALIGN_LAST;
          end else begin
            state_next_s = IDLE;
          end
        end
        ALIGN: begin
          power_next_s = align_lvl_s;
          if (!ENABLE) begin
            state_next_s = RAMP_DOWN;
          end else if (align_r == ALIGN_ZERO) begin
            state_next_s = RAMP_UP;
          end else begin
            align_next_s = align_r - AW'(1);
          end
        end
        RAMP_UP, RUN: begin
          if (!ENABLE) begin
            state_next_s = RAMP_DOWN;
          end else if (tick_s) begin
            power_next_s = toward_s;
            state_next_s = (toward_s == TARGET) ? RUN : state_r;
          end else begin
            power_next_s = power_r;
          end
        end
        RAMP_DOWN: begin
          if (tick_s) begin
            power_next_s = dn_s;
            state_next_s = (dn_s == P_ZERO) ? IDLE : RAMP_DOWN;
          end else begin
            power_next_s = power_r;
          end
        end
        FAULT: begin
          power_next_s = P_ZERO;
          if (CLR_FAULT && !FAULT_IN && !ENABLE) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = FAULT;
          end
        end
        default: begin
          state_next_s = IDLE;
          power_next_s = P_ZERO;
        end
      endcase
    end
  end

  // State, POWER, config word and status flags are all registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      power_r   <= P_ZERO;
      align_r   <= ALIGN_ZERO;
      mod_r     <= CFG_RESET;
      running_r <= 1'b0;
      busy_r    <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      power_r   <= power_next_s;
      align_r   <= align_next_s;
      if (state_r == IDLE) begin
        mod_r <= cfg_s;
      end else begin
        mod_r <= mod_r;
      end
      running_r <= (state_next_s == RUN);
      busy_r    <= (state_next_s != IDLE) && (state_next_s != FAULT);
      fault_r   <= (state_next_s == FAULT);
    end
  end

  assign POWER          = power_r;
  assign MOD_DELAY_UMIN = mod_r;
  assign RUNNING        = running_r;
  assign BUSY           = busy_r;
  assign FAULT_LATCHED  = fault_r;

endmodule
